// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and error strobes.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx #(
  parameter int TICKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_error,
  output logic       parity_error,
  output logic       busy
);

  localparam logic [7:0] HALF_M1 = 8'(TICKS_PER_BIT / 2 - 1);
  localparam logic [7:0] TERM    = 8'(TICKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3,
    S_WAIT_HIGH = 3'd4, S_PARITY = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;
`endif

  state_t      state, state_n;
  logic        rx_q1, rx_s;
  logic [7:0]  tick;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        half_hit, bit_hit;

  assign half_hit = (tick == HALF_M1);
  assign bit_hit  = (tick == TERM);
  assign busy     = (state != S_IDLE);

  // Two-flop synchronizer, preset high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (!rx_s) state_n = S_START;
      S_START:     if (half_hit) state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (bit_hit && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY:    if (bit_hit) state_n = S_STOP;
`endif
      S_STOP:      if (bit_hit) state_n = rx_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_strobe;
  assign parity_error = par_strobe;
`else
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick        <= 8'd0;
      bit_idx     <= 3'd0;
      shift       <= 8'd0;
      data_out    <= 8'd0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      par_strobe  <= 1'b0;
`endif
    end else begin
      valid       <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_strobe  <= 1'b0;
`endif
      case (state)
        S_START: begin
          tick    <= half_hit ? 8'd0 : tick + 8'd1;
          bit_idx <= 3'd0;
        end
        S_DATA: begin
          if (bit_hit) begin
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            tick           <= 8'd0;
          end else begin
            tick <= tick + 8'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_hit) begin
            par_bad <= (^shift) ^ rx_s;
            tick    <= 8'd0;
          end else begin
            tick <= tick + 8'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_hit) begin
            tick <= 8'd0;
            // A low stop bit outranks a parity mismatch
            if (!rx_s) begin
              frame_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              par_strobe <= 1'b1;
`endif
            end else begin
              data_out <= shift;
              valid    <= 1'b1;
            end
          end else begin
            tick <= tick + 8'd1;
          end
        end
        default: begin
          tick    <= 8'd0;
          bit_idx <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with randomized frames.
module tb_uart_rx;

  localparam int T = 87;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + T / 2 + 10 * T;
`else
  localparam int LAT = 2 + T / 2 + 9 * T;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_error, parity_error, busy;

  uart_rx #(.TICKS_PER_BIT(T)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_out(data_out), .valid(valid),
    .frame_error(frame_error), .parity_error(parity_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 valid, 1 frame_error, 2 parity_error
    logic [7:0] data;   // data_out expected at the strobe
    int         t;      // expected strobe cycle
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;
  bit         prev_strobe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever any strobe appears
  always @(negedge clk) begin
    int  kind;
    int  n;
    ev_t e;
    n = int'(valid) + int'(frame_error) + int'(parity_error);
    if (n != 0) begin
      checks++;
      if (n != 1 || prev_strobe) begin
        errors++;
        $display("FAIL strobe_excl: got %0d strobes prev=%0d expected 1 prev=0", n, prev_strobe);
      end
      kind = valid ? 0 : (frame_error ? 1 : 2);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe: got kind %0d data %0h expected none", kind, data_out);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", kind, e.kind);
        chk("data_out", {24'd0, data_out}, {24'd0, e.data});
        checks++;
        if (cyc < e.t - 3 || cyc > e.t + 3) begin
          errors++;
          $display("FAIL latency: got cycle %0d expected %0d +-3", cyc, e.t);
        end
      end
    end
    prev_strobe = (n != 0);
  end

  // Sends one frame starting at a negedge; stop_low > 0 holds the stop bit low
  task automatic send_frame(input logic [7:0] b, input bit p, input int stop_low);
    ev_t e;
    bit  par_ok;
    par_ok = ($countones(b) + int'(p)) % 2 == 0;
`ifndef UART_RX_PARITY_EN
    par_ok = 1'b1;
`endif
    e.t = cyc + LAT;
    if (stop_low > 0) begin
      e.kind = 1; e.data = last_good;
    end else if (!par_ok) begin
      e.kind = 2; e.data = last_good;
    end else begin
      e.kind = 0; e.data = b; last_good = b;
    end
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (T) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = p;
    repeat (T) @(negedge clk);
`endif
    if (stop_low > 0) begin
      rx = 1'b0;
      repeat (stop_low) @(negedge clk);
      chk("busy_wait_high", {31'd0, busy}, 32'd1);
      rx = 1'b1;
    end else begin
      rx = 1'b1;
      repeat (T) @(negedge clk);
    end
  endtask

  function automatic bit even_par(input logic [7:0] b);
    return ($countones(b) % 2) != 0;
  endfunction

  initial begin
    logic [7:0] b;
    int         gap;
    int         bad;
    int         budget;

    repeat (3) @(negedge clk);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_frame_error", {31'd0, frame_error}, 32'd0);
    chk("rst_parity_error", {31'd0, parity_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'hA5, even_par(8'hA5), 0);
    repeat (20) @(negedge clk);
    chk("busy_after_a5", {31'd0, busy}, 32'd0);

    send_frame(8'h00, even_par(8'h00), 0);
    send_frame(8'hFF, even_par(8'hFF), 0);
    repeat (20) @(negedge clk);

    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy_high", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_busy_low", {31'd0, busy}, 32'd0);
    chk("glitch_data_out", {24'd0, data_out}, {24'd0, last_good});

    send_frame(8'h3C, even_par(8'h3C), 200);
    repeat (5) @(negedge clk);
    chk("busy_after_wait_high", {31'd0, busy}, 32'd0);
    send_frame(8'h81, even_par(8'h81), 0);
    repeat (10) @(negedge clk);

    // Abort 0x5A partway through data bit 4
    b = 8'h5A;
    rx = 1'b0;
    repeat (T) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (T) @(negedge clk);
    end
    rx = b[4];
    repeat (40) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_data_out", {24'd0, data_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h5A, even_par(8'h5A), 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 0);
    send_frame(8'h07, 1'b0, 0);
    repeat (10) @(negedge clk);
`endif

    for (int k = 0; k < 10; k++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(T, 200)) : 0;
      gap = (bad > 0) ? int'($urandom_range(4, 50)) : int'($urandom_range(0, 100));
`ifdef UART_RX_PARITY_EN
      send_frame(b, ($urandom_range(0, 3) == 0) ? ~even_par(b) : even_par(b), bad);
`else
      send_frame(b, 1'b0, bad);
`endif
      repeat (gap) @(negedge clk);
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that sits directly downstream of the UART transmitter; accepts the serial line and returns bytes.
- Frame format: 8N1, LSB first: start bit (0), 8 data bits, stop bit (1).
- Runs from a system clock using the same ticks-per-bit timing as the transmitter.
- Delivers each good byte with a one-cycle valid strobe and flags malformed frames.

Parameters:
- TICKS_PER_BIT, 87, clock ticks per bit period (10 MHz / 115200). Legal range 4..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk; idles high.
- data_out  output  8  last correctly received byte.
- valid  output  1  one-cycle pulse when data_out is updated.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_error  output  1  one-cycle pulse on parity mismatch (see Optional Feature).
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (reset low, asynchronous):
  - data_out=0x00; valid, frame_error, parity_error and busy = 0.
  - State=IDLE; bit counter and tick counter = 0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame abandons the frame; no strobe is emitted.
- Input synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Tick counter: 8 bits; wraps to 0 on each terminal count.
- IDLE:
  - busy=0.
  - rx_s==0 -> START, tick counter cleared.
- START:
  - busy=1.
  - At tick==TICKS_PER_BIT/2-1 (integer divide; 42 for 87), sample rx_s:
  - rx_s==0 -> DATA, tick counter=0, bit index=0.
  - rx_s==1 -> IDLE. This is a glitch; no strobe is emitted.
- DATA:
  - At tick==TICKS_PER_BIT-1, shift rx_s into bit[bit index]. LSB is received first.
  - Increment bit index and clear the tick counter.
  - After bit 7 -> PARITY if the feature is enabled, otherwise -> STOP.
- PARITY (feature only):
  - At terminal tick, sample the parity bit and latch the mismatch result -> STOP.
- STOP:
  - At terminal tick, sample rx_s.
  - Sample 1, no parity mismatch: data_out<=shift register; valid=1 for one cycle -> IDLE.
  - Sample 1, parity mismatch: parity_error=1 for one cycle; data_out unchanged -> IDLE.
  - Sample 0: frame_error=1 for one cycle; data_out unchanged -> WAIT_HIGH. frame_error takes precedence over parity_error; never both.
- WAIT_HIGH:
  - busy=1 until rx_s==1, then -> IDLE. This prevents a held-low line from starting spurious frames.
- Strobes are mutually exclusive and never assert on consecutive cycles.
- Returning to IDLE at mid-stop-bit allows a following start bit to be accepted immediately: back-to-back frames with zero idle time must work.
- Latency: the valid rising edge lands within ±3 clk of 2 + TICKS_PER_BIT/2 + 9×TICKS_PER_BIT cycles after the rx falling edge of the start bit. Add one TICKS_PER_BIT when parity is enabled.
- data_out holds its value between frames.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit is expected between data bit 7 and the stop bit.
  - Mismatch (XOR of 8 data bits and the parity bit equals 1) gives a parity_error pulse; data_out is not updated and valid is not asserted.
- Undefined:
  - No PARITY state; the frame is 10 bits.
  - parity_error is tied to 0.

Test Plan:
- Loopback from transmitter (TICKS_PER_BIT=87) sending 0xA5 -> exactly one valid pulse; data_out=0xA5; frame_error=0; busy drops after the frame.
- Back-to-back 0x00 then 0xFF, zero idle time -> two valid pulses about 870 cycles apart; data_out 0x00 then 0xFF.
- rx pulsed low for 20 cycles, then high -> busy rises then falls; no valid or frame_error; data_out unchanged.
- Frame 0x3C with stop bit forced low for 200 cycles -> frame_error pulse; no valid; data_out keeps its previous value; busy stays high until rx returns high; a following 0x81 is received correctly.
- reset driven low during data bit 4 of 0x5A -> outputs return to reset values immediately; no strobe; the next full frame 0x5A is received correctly.
- With UART_RX_PARITY_EN defined:
  - 0x07 with parity bit 1 -> valid; data_out=0x07.
  - 0x07 with parity bit 0 -> parity_error pulse; no valid.
